centroid_smoother: RTL and testbench

- Sits directly downstream of the per-frame centre-of-mass stage and consumes its x/y/valid output pulse.
- Produces a moving average over the last 2^LOG_DEPTH centroids so the renderer/tracker sees a stable position.
- Tracks frames that produce no centroid; after MAX_MISS consecutive empty frames it drops the history and flags loss of track.

---
 rtl/centroid_smoother.sv | 138 +++++++++++++
 tb/tb_centroid_smoother.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/centroid_smoother.sv
// Moving-average smoother for per-frame centroids, with miss tracking that
// drops the history after MAX_MISS consecutive empty frames.
module centroid_smoother #(
    parameter int LOG_DEPTH = 2,
    parameter int MAX_MISS  = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        frame_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        tracking_out,
    output logic        lost_out
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int SX    = 11 + LOG_DEPTH;
    localparam int SY    = 10 + LOG_DEPTH;

    typedef enum logic {EMPTY, TRACK} state_t;

    state_t               state_reg, state_next;
    logic [SX-1:0]        sum_x_reg;
    logic [SY-1:0]        sum_y_reg;
    logic [LOG_DEPTH-1:0] ptr_reg;
    logic [3:0]           miss_reg;
    logic                 seen_reg;
    logic                 stage1_reg;
    logic [10:0]          buf_x [DEPTH];
    logic [9:0]           buf_y [DEPTH];

    logic       preload, accept, flush, miss_clear, miss_inc;
    logic [4:0] miss_plus;

    assign miss_plus    = {1'b0, miss_reg} + 5'd1;
    assign tracking_out = (state_reg == TRACK);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_reg <= EMPTY;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        preload    = 1'b0;
        accept     = 1'b0;
        flush      = 1'b0;
        miss_clear = 1'b0;
        miss_inc   = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (valid_in) begin
                    preload    = 1'b1;
                    state_next = TRACK;
                end
            end
            TRACK: begin
                accept = valid_in;
                if (frame_in) begin
                    // A sample arriving with the frame strobe belongs to the closing frame.
                    if (seen_reg || valid_in) begin
                        miss_clear = 1'b1;
                    end else if (miss_plus == 5'(MAX_MISS)) begin
                        flush      = 1'b1;
                        state_next = EMPTY;
                    end else begin
                        miss_inc = 1'b1;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Entry on track acquisition fills the whole window so the first average is exact.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
            always_ff @(posedge clk_in) begin
                if (preload || (accept && ptr_reg == LOG_DEPTH'(gi))) begin
                    buf_x[gi] <= x_in;
                    buf_y[gi] <= y_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_x_reg  <= '0;
            sum_y_reg  <= '0;
            ptr_reg    <= '0;
            miss_reg   <= '0;
            seen_reg   <= 1'b0;
            stage1_reg <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            valid_out  <= 1'b0;
            lost_out   <= 1'b0;
        end else begin
            if (preload) begin
                sum_x_reg <= {x_in, {LOG_DEPTH{1'b0}}};
                sum_y_reg <= {y_in, {LOG_DEPTH{1'b0}}};
                ptr_reg   <= '0;
            end else if (accept) begin
                sum_x_reg <= sum_x_reg + SX'(x_in) - SX'(buf_x[ptr_reg]);
                sum_y_reg <= sum_y_reg + SY'(y_in) - SY'(buf_y[ptr_reg]);
                ptr_reg   <= ptr_reg + LOG_DEPTH'(1);
            end else if (flush) begin
                sum_x_reg <= '0;
                sum_y_reg <= '0;
                ptr_reg   <= '0;
            end

            if (preload || miss_clear || flush) miss_reg <= '0;
            else if (miss_inc)                  miss_reg <= miss_plus[3:0];

            if (preload)                 seen_reg <= ~frame_in;
            else if (state_reg == TRACK) begin
                if (frame_in)            seen_reg <= 1'b0;
                else if (valid_in)       seen_reg <= 1'b1;
            end

            // Stage 2 reads the pre-flush sums, so a pending output still emits.
            stage1_reg <= preload | accept;
            valid_out  <= stage1_reg;
            if (stage1_reg) begin
                x_out <= sum_x_reg[SX-1:LOG_DEPTH];
                y_out <= sum_y_reg[SY-1:LOG_DEPTH];
            end
            lost_out <= flush;
        end
    end

endmodule

// File: tb/tb_centroid_smoother.sv
// Scoreboard bench for centroid_smoother: stimulus queues expected outputs
// and loss pulses, a negedge monitor matches them against the DUT.
module tb_centroid_smoother;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic        frame_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out, tracking_out, lost_out;

    centroid_smoother #(.LOG_DEPTH(2), .MAX_MISS(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .frame_in(frame_in), .x_out(x_out), .y_out(y_out),
        .valid_out(valid_out), .tracking_out(tracking_out), .lost_out(lost_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;

    exp_t out_q[$];
    int   lost_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   failures = 0;
    exp_t mon_e;
    int   mon_c;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (valid_out) begin
            tests++;
            if (out_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid cyc=%0d got (%0d,%0d) required no output", cyc, x_out, y_out);
            end else begin
                mon_e = out_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.x != x_out || mon_e.y != y_out) begin
                    failures++;
                    $display("FAIL output cyc=%0d got (%0d,%0d) required (%0d,%0d) at cyc %0d",
                             cyc, x_out, y_out, mon_e.x, mon_e.y, mon_e.cyc);
                end else begin
                    $display("[TB] out cyc=%0d (%0d,%0d) ok", cyc, x_out, y_out);
                end
            end
        end else if (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
            tests++;
            failures++;
            mon_e = out_q.pop_front();
            $display("FAIL missing_valid cyc=%0d got none required (%0d,%0d)", cyc, mon_e.x, mon_e.y);
        end

        if (lost_out) begin
            tests++;
            if (lost_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_lost cyc=%0d got lost_out=1 required 0", cyc);
            end else begin
                mon_c = lost_q.pop_front();
                if (mon_c != cyc) begin
                    failures++;
                    $display("FAIL lost_timing got cyc %0d required cyc %0d", cyc, mon_c);
                end else begin
                    $display("[TB] lost pulse cyc=%0d ok", cyc);
                end
            end
        end else if (lost_q.size() > 0 && lost_q[0] <= cyc) begin
            tests++;
            failures++;
            mon_c = lost_q.pop_front();
            $display("FAIL missing_lost cyc=%0d got 0 required pulse at cyc %0d", cyc, mon_c);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end else begin
            $display("[TB] %s = %0d ok", name, act);
        end
    endtask

    task automatic step(input logic v, input logic f, input logic [10:0] x, input logic [9:0] y);
        @(negedge clk_in);
        valid_in = v;
        frame_in = f;
        x_in     = x;
        y_in     = y;
    endtask

    task automatic send(input logic [10:0] x, input logic [9:0] y,
                        input logic [10:0] ex, input logic [9:0] ey, input logic f);
        exp_t e;
        step(1'b1, f, x, y);
        e.cyc = cyc + 2;
        e.x   = ex;
        e.y   = ey;
        out_q.push_back(e);
    endtask

    task automatic frame(input logic expect_lost);
        step(1'b0, 1'b1, '0, '0);
        if (expect_lost) lost_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        chk("reset_x_out", x_out, 0);
        chk("reset_y_out", y_out, 0);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_tracking", tracking_out, 0);
        chk("reset_lost", lost_out, 0);
        rst_in = 1'b0;
        idle(1);

        // Acquisition and window averaging
        send(11'd100, 10'd200, 11'd100, 10'd200, 1'b0);
        send(11'd104, 10'd204, 11'd101, 10'd201, 1'b0);
        send(11'd108, 10'd208, 11'd103, 10'd203, 1'b0);
        send(11'd112, 10'd212, 11'd106, 10'd206, 1'b0);
        idle(3);
        chk("tracking_after_acquire", tracking_out, 1);

        // Close the data frame, then three empty frames
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        frame(1'b1);
        idle(2);
        chk("tracking_after_lost", tracking_out, 0);
        send(11'd500, 10'd300, 11'd500, 10'd300, 1'b0);
        idle(3);

        // Sample coinciding with frame strobe resets the miss count
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        send(11'd500, 10'd300, 11'd500, 10'd300, 1'b1);
        frame(1'b0);
        frame(1'b0);
        idle(1);
        chk("tracking_after_two_misses", tracking_out, 1);
        frame(1'b1);
        idle(2);
        chk("tracking_after_second_lost", tracking_out, 0);
        chk("x_hold_after_lost", x_out, 500);

        // Frame strobes in EMPTY are ignored
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        idle(1);

        // Full-scale samples back to back
        for (int i = 0; i < 8; i++) send(11'd2047, 10'd1023, 11'd2047, 10'd1023, 1'b0);
        idle(3);
        chk("x_hold_full_scale", x_out, 2047);

        // Asynchronous reset between sample and output
        step(1'b1, 1'b0, 11'd10, 10'd20);
        step(1'b0, 1'b0, '0, '0);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_x_out", x_out, 0);
        chk("async_rst_y_out", y_out, 0);
        chk("async_rst_tracking", tracking_out, 0);
        @(negedge clk_in);
        chk("async_rst_valid_out", valid_out, 0);
        rst_in = 1'b0;
        send(11'd100, 10'd200, 11'd100, 10'd200, 1'b0);
        idle(4);
        chk("tracking_after_reacquire", tracking_out, 1);

        chk("pending_outputs_left", out_q.size(), 0);
        chk("pending_lost_left", lost_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
